// File: rtl/grf_scoreboard.sv
// grf_scoreboard: 32 x 32-bit general register file fused with a per-register
// destination scoreboard. Issue marks a destination pending, write-back commits
// the data and retires one pending mark. Reads are bypassed from write-back and
// report whether an outstanding writer still exists.
// Optional feature macro: GRF_DISPLAY_EN (prints each committed write).
module grf_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        busy1,
  output logic        busy2,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [CNT_W-1:0] cnt_q  [32];
  logic [CNT_W-1:0] cnt_d  [32];
  logic             err_q;
  logic             err_d;
  logic             inc;
  logic             dec;
  logic             wb_hit1;
  logic             wb_hit2;

  // Next-state for register data, in-flight counters and the sticky error flag.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (wb_valid && (wb_addr != 5'd0)) begin
      regs_d[wb_addr] = wb_data;
    end
    for (int a = 1; a < 32; a++) begin
      inc = issue_valid && (issue_addr == 5'(a));
      dec = wb_valid && (wb_addr == 5'(a));
      if (inc && !dec) begin
        if (cnt_q[a] == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[a] = cnt_q[a] + CNT_ONE;
        end
      end else if (dec && !inc) begin
        if (cnt_q[a] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[a] = cnt_q[a] - CNT_ONE;
        end
      end
    end
    regs_d[0] = '0;
    cnt_d[0]  = '0;
  end

  // State registers; the synchronous active-low reset drops every pending mark.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

`ifdef GRF_DISPLAY_EN
  // Trace every committed write, including ones that underflow the counter.
  always_ff @(posedge clk) begin
    if (reset && wb_valid && (wb_addr != 5'd0)) begin
      $display("@%h: $%d <= %h", wb_pc, wb_addr, wb_data);
    end
  end
`else
  logic unused_wb_pc;
  assign unused_wb_pc = ^wb_pc;
`endif

  // Bypassed reads: a same-cycle write-back is visible with zero latency.
  always_comb begin
    wb_hit1 = wb_valid && (wb_addr == ra1);
    wb_hit2 = wb_valid && (wb_addr == ra2);
    rd1 = (ra1 == 5'd0) ? 32'd0 : (wb_hit1 ? wb_data : regs_q[ra1]);
    rd2 = (ra2 == 5'd0) ? 32'd0 : (wb_hit2 ? wb_data : regs_q[ra2]);
    busy1 = (ra1 != 5'd0) && (cnt_q[ra1] != '0) &&
            !(wb_hit1 && (cnt_q[ra1] == CNT_ONE));
    busy2 = (ra2 != 5'd0) && (cnt_q[ra2] != '0) &&
            !(wb_hit2 && (cnt_q[ra2] == CNT_ONE));
  end

  assign err = err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard with hand-computed expectations.
module tb_grf_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        busy1;
  logic        busy2;
  logic        err;

  int checks;
  int errors;

  grf_scoreboard #(.CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_addr(issue_addr),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .wb_pc(wb_pc),
    .ra1(ra1),
    .ra2(ra2),
    .rd1(rd1),
    .rd2(rd2),
    .busy1(busy1),
    .busy2(busy2),
    .err(err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge and let the read path settle.
  task automatic applyStimulus(input logic rst_n, input logic iv, input logic [4:0] ia,
                               input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    reset       = rst_n;
    issue_valid = iv;
    issue_addr  = ia;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
    wb_pc       = 32'h0040_0000 + {27'd0, wa};
    ra1         = r1;
    ra2         = r2;
    #1;
  endtask

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    wb_valid    = 1'b1;
    wb_addr     = 5'd5;
    wb_data     = 32'd7;
    wb_pc       = 32'd0;
    ra1         = 5'd5;
    ra2         = 5'd0;

    // Reset held for two edges while a write-back to $5 is presented.
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'd7, 5'd5, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd8);
    checkOutput("rst_reg5", rd1, 32'd0);
    checkOutput("rst_busy1", {31'd0, busy1}, 32'd0);
    checkOutput("rst_busy2", {31'd0, busy2}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);

    // Issue to $8: not busy in the issuing cycle, busy afterwards.
    applyStimulus(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
    checkOutput("iss8_same_busy", {31'd0, busy1}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
    checkOutput("iss8_next_busy", {31'd0, busy1}, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 32'hDEAD, 5'd8, 5'd0);
    checkOutput("wb8_bypass_rd", rd1, 32'hDEAD);
    checkOutput("wb8_bypass_busy", {31'd0, busy1}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
    checkOutput("wb8_after_rd", rd1, 32'hDEAD);
    checkOutput("wb8_after_busy", {31'd0, busy1}, 32'd0);

    // Two writers to $9: first commit leaves it busy, second clears it.
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    checkOutput("cnt9_two_busy", {31'd0, busy2}, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd9);
    checkOutput("wb9_first_busy", {31'd0, busy2}, 32'd1);
    checkOutput("wb9_first_rd", rd2, 32'h99);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 32'h9A, 5'd0, 5'd9);
    checkOutput("wb9_second_busy", {31'd0, busy2}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd9);
    checkOutput("wb9_done_busy", {31'd0, busy2}, 32'd0);
    checkOutput("wb9_done_rd", rd2, 32'h9A);

    // Simultaneous issue and commit to $4 with one in flight keeps the count at 1.
    applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 32'h44, 5'd4, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    checkOutput("both4_busy", {31'd0, busy1}, 32'd1);
    checkOutput("both4_rd", rd1, 32'h44);
    checkOutput("both4_err", {31'd0, err}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd4, 32'h45, 5'd4, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    checkOutput("drain4_busy", {31'd0, busy1}, 32'd0);

    // $0 ignores writes and reads as zero, not busy.
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    checkOutput("r0_bypass_rd", rd1, 32'd0);
    checkOutput("r0_busy", {31'd0, busy1}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("r0_after_rd", rd1, 32'd0);
    checkOutput("r0_err", {31'd0, err}, 32'd0);

    // Underflow on $12: data still written, err set.
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd12, 32'h12, 5'd12, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    checkOutput("uf12_rd", rd1, 32'h12);
    checkOutput("uf12_err", {31'd0, err}, 32'd1);
    checkOutput("uf12_busy", {31'd0, busy1}, 32'd0);

    // Load $3 with data and two pending writers, then reset mid-operation.
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd12);
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd3, 5'd12);
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd3, 5'd12);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd12);
    checkOutput("pre_rst3_busy", {31'd0, busy1}, 32'd1);
    checkOutput("pre_rst3_rd", rd1, 32'h33);
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 5'd12, 32'h77, 5'd3, 5'd12);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd12);
    checkOutput("rst3_busy", {31'd0, busy1}, 32'd0);
    checkOutput("rst3_rd", rd1, 32'd0);
    checkOutput("rst12_rd", rd2, 32'd0);
    checkOutput("rst_err_clear", {31'd0, err}, 32'd0);

    // Four issues to $13 saturate at 3 and set err; three commits then drain it.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 5'd13, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    end
    applyStimulus(1'b1, 1'b1, 5'd13, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    checkOutput("ov13_pre_err", {31'd0, err}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    checkOutput("ov13_err", {31'd0, err}, 32'd1);
    checkOutput("ov13_busy", {31'd0, busy1}, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd13, 32'h131, 5'd13, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd13, 32'h132, 5'd13, 5'd0);
    checkOutput("ov13_cnt2_busy", {31'd0, busy1}, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    checkOutput("ov13_cnt1_busy", {31'd0, busy1}, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd13, 32'h133, 5'd13, 5'd0);
    checkOutput("ov13_last_busy", {31'd0, busy1}, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    checkOutput("ov13_drained_busy", {31'd0, busy1}, 32'd0);
    checkOutput("ov13_final_rd", rd1, 32'h133);
    checkOutput("ov13_err_sticky", {31'd0, err}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
